// File: rtl/mpu_add_sequencer.sv
// Element-serial sequencer for the MPU matrix add: reads A and B element pairs from the
// single-port matrix RAM, adds them, and writes C over an active SIZE x SIZE window.
module mpu_add_sequencer #(
  parameter int DATA_W   = 8,
  parameter int DIM      = 5,
  parameter int ADDR_W   = 8,
  parameter int SATURATE = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              overflow,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_base_c;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [DATA_W-1:0] r_a;
  logic              r_ovf_sticky;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_overflow;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_next_off;
  logic [2:0]        w_next_row;
  logic [2:0]        w_next_col;
  logic              w_last_col;
  logic              w_last;
  logic              w_size_bad;
  logic [DATA_W:0]   w_sum;
  logic              w_carry;
  logic [DATA_W-1:0] w_wr_val;

  // Row stride is always DIM; offsets wrap modulo 2^ADDR_W with the address
  assign w_off      = ADDR_W'(r_row) * ADDR_W'(DIM) + ADDR_W'(r_col);
  assign w_last_col = (r_col == r_size - 3'd1);
  assign w_last     = w_last_col && (r_row == r_size - 3'd1);
  assign w_next_col = w_last_col ? '0 : r_col + 3'd1;
  assign w_next_row = w_last_col ? r_row + 3'd1 : r_row;
  assign w_next_off = ADDR_W'(w_next_row) * ADDR_W'(DIM) + ADDR_W'(w_next_col);
  assign w_size_bad = (size == 3'd0) || (int'(size) > DIM);

  assign w_sum    = {1'b0, r_a} + {1'b0, mem_rd_data};
  assign w_carry  = w_sum[DATA_W];
  assign w_wr_val = ((SATURATE != 0) && w_carry) ? '1 : w_sum[DATA_W-1:0];

  // B arrives during the WR cycle itself, so write data is formed combinationally
  // and gated so it reads zero whenever no write is in progress.
  assign mem_wr_data = r_wr_en ? w_wr_val : '0;

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign overflow    = r_overflow;
  assign mem_rd_en   = r_rd_en;
  assign mem_rd_addr = r_rd_addr;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_size       <= '0;
      r_base_a     <= '0;
      r_base_b     <= '0;
      r_base_c     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_a          <= '0;
      r_ovf_sticky <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_overflow   <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_size       <= size;
            r_base_a     <= base_a;
            r_base_b     <= base_b;
            r_base_c     <= base_c;
            r_row        <= '0;
            r_col        <= '0;
            r_ovf_sticky <= 1'b0;
            if (w_size_bad) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_error    <= 1'b1;
              r_overflow <= 1'b0;
            end else begin
              r_state   <= S_RD_A;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= base_a;
            end
          end
        end
        S_RD_A: begin
          r_state   <= S_RD_B;
          r_rd_addr <= r_base_b + w_off;
        end
        S_RD_B: begin
          r_state   <= S_WR;
          r_a       <= mem_rd_data;
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_base_c + w_off;
        end
        S_WR: begin
          r_wr_en      <= 1'b0;
          r_wr_addr    <= '0;
          r_ovf_sticky <= r_ovf_sticky | w_carry;
          r_row        <= w_next_row;
          r_col        <= w_next_col;
          if (w_last) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= 1'b0;
            r_overflow <= r_ovf_sticky | w_carry;
            r_row      <= '0;
            r_col      <= '0;
          end else begin
            r_state   <= S_RD_A;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_base_a + w_next_off;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_error    <= 1'b0;
          r_overflow <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_add_sequencer.sv
// Directed bench for mpu_add_sequencer: table of add commands against a pattern-driven
// memory model, plus start-while-busy and mid-run reset sequences.
module tb_mpu_add_sequencer;

  typedef struct {
    logic [2:0] size;
    logic [7:0] base_a;
    logic [7:0] base_b;
    logic [7:0] base_c;
    logic [7:0] a_step;
    logic [7:0] a_ofs;
    logic [7:0] b_val;
    logic       exp_err;
    logic       exp_ovf;
    int         exp_lat;
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [2:0] size;
  logic [7:0] base_a, base_b, base_c;
  logic       busy, done, error, overflow;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [7:0] mem_rd_data = '0;

  int checks   = 0;
  int failures = 0;
  int wcount   = 0;
  int done_cnt = 0;
  int both_cnt = 0;
  int stray_cnt = 0;
  logic [7:0] wlog_addr [0:1023];
  logic [7:0] wlog_data [0:1023];

  vec_t tv [0:6];
  vec_t cur;

  mpu_add_sequencer #(.DATA_W(8), .DIM(5), .ADDR_W(8), .SATURATE(0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .size(size),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .error(error), .overflow(overflow),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] a_val(input int r, input int c);
    logic [7:0] t;
    t = 8'(int'(cur.a_step) * (r * 5 + c));
    return t + cur.a_ofs;
  endfunction

  // Memory contents are a function of the current command: A window, B window, else 0xEE
  function automatic logic [7:0] pat(input logic [7:0] addr);
    logic [7:0] oa, ob;
    oa = addr - cur.base_a;
    ob = addr - cur.base_b;
    for (int r = 0; r < int'(cur.size); r++)
      for (int c = 0; c < int'(cur.size); c++) begin
        if (oa == 8'(r * 5 + c)) return a_val(r, c);
        if (ob == 8'(r * 5 + c)) return cur.b_val;
      end
    return 8'hEE;
  endfunction

  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);
    if (mem_wr_en) begin
      if (wcount < 1024) begin
        wlog_addr[wcount] <= mem_wr_addr;
        wlog_data[wcount] <= mem_wr_data;
      end
      wcount <= wcount + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    if (!busy && (mem_rd_en || mem_wr_en)) stray_cnt <= stray_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input bit repulse);
    int w0, d0, lat, n, nexp, nw;
    logic got_err, got_ovf;
    logic [7:0] ea, ed, av, bv;
    logic [8:0] s9;
    cur = tv[idx];
    n = int'(cur.size);
    w0 = wcount;
    d0 = done_cnt;
    lat = 0;
    got_err = 1'bx;
    got_ovf = 1'bx;
    @(negedge clock);
    start = 1'b1; size = cur.size;
    base_a = cur.base_a; base_b = cur.base_b; base_c = cur.base_c;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        lat = k; got_err = error; got_ovf = overflow;
        break;
      end
      if (repulse && (k == 5 || k == 20)) begin
        start = 1'b1; size = 3'd2; base_a = 8'd200; base_b = 8'd210; base_c = 8'd220;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check($sformatf("lat[%0d]", idx), lat, cur.exp_lat);
    check($sformatf("err[%0d]", idx), {31'd0, got_err}, {31'd0, cur.exp_err});
    check($sformatf("ovf[%0d]", idx), {31'd0, got_ovf}, {31'd0, cur.exp_ovf});
    repeat (2) @(negedge clock);
    check($sformatf("done_pulses[%0d]", idx), done_cnt - d0, 1);
    nexp = cur.exp_err ? 0 : n * n;
    nw = wcount - w0;
    check($sformatf("writes[%0d]", idx), nw, nexp);
    for (int k = 0; k < nexp && k < nw; k++) begin
      av = a_val(k / n, k % n);
      bv = cur.b_val;
      s9 = {1'b0, av} + {1'b0, bv};
      ed = s9[7:0];
      ea = cur.base_c + 8'((k / n) * 5 + (k % n));
      check($sformatf("wr[%0d].%0d", idx, k), {16'd0, wlog_addr[w0 + k], wlog_data[w0 + k]},
            {16'd0, ea, ed});
    end
  endtask

  task automatic reset_abort;
    int w0, d0;
    bit reached;
    cur = tv[0];
    w0 = wcount;
    d0 = done_cnt;
    reached = 1'b0;
    @(negedge clock);
    start = 1'b1; size = cur.size;
    base_a = cur.base_a; base_b = cur.base_b; base_c = cur.base_c;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (wcount - w0 == 6) begin reached = 1'b1; break; end
      @(negedge clock);
    end
    check("abort_reach_elem7", {31'd0, reached}, 32'd1);
    @(negedge clock);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs_async", {2'd0, busy, done, error, overflow, mem_rd_en, mem_wr_en,
          mem_rd_addr, mem_wr_addr, mem_wr_data}, 32'd0);
    repeat (5) @(negedge clock);
    check("abort_writes", wcount - w0, 6);
    check("abort_no_done", done_cnt - d0, 0);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        size base_a base_b base_c step  ofs    b      err   ovf   lat
    tv[0] = '{3'd5, 8'd0,   8'd25,  8'd50,  8'd1, 8'h00, 8'h01, 1'b0, 1'b0, 76};
    tv[1] = '{3'd2, 8'd100, 8'd110, 8'd120, 8'd0, 8'h80, 8'h80, 1'b0, 1'b1, 13};
    tv[2] = '{3'd0, 8'd0,   8'd25,  8'd50,  8'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1};
    tv[3] = '{3'd6, 8'd0,   8'd25,  8'd50,  8'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1};
    tv[4] = '{3'd2, 8'd10,  8'd20,  8'hFE,  8'd0, 8'h03, 8'h04, 1'b0, 1'b0, 13};
    tv[5] = '{3'd1, 8'd0,   8'd1,   8'd2,   8'd0, 8'hFF, 8'h01, 1'b0, 1'b1, 4};
    tv[6] = '{3'd3, 8'd30,  8'd60,  8'd90,  8'd2, 8'h10, 8'h20, 1'b0, 1'b0, 28};
    cur = tv[0];

    reset_n = 1'b0; start = 1'b0; size = '0;
    base_a = '0; base_b = '0; base_c = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {2'd0, busy, done, error, overflow, mem_rd_en, mem_wr_en,
          mem_rd_addr, mem_wr_addr, mem_wr_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(i, 1'b0);

    run_vec(0, 1'b1);
    run_vec(5, 1'b0);

    reset_abort();
    run_vec(0, 1'b0);

    check("rd_wr_overlap", both_cnt, 0);
    check("strobe_outside_busy", stray_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
